micro_sequencer: RTL

- Multi-cycle CPU next-state engine.
- Holds the 4-bit state register and sequences each instruction through fetch, decode, execute, memory and writeback states, using the instruction opcode and memory-ready handshake.
- Drives `current_state` into the combinational control unit, which turns each state into datapath control signals.
- Also owns the sticky halt flag and instruction-retire accounting.

---
 rtl/micro_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/micro_sequencer.sv
// Purpose: multi-cycle CPU next-state engine with sticky halt and optional retire/cycle counters.
// Latency: every output is registered; a transition decided in cycle N appears in cycle N+1.
// Backpressure: mem_ready=0 holds IF_PC, MEM_READ and MEM_WRITE; it is ignored in every other state.
//
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   part_of_inst[6:0] - opcode field of the instruction register
//   mem_ready         - memory finished the current access this cycle
//   halt_req          - ECALL halt condition, sampled only in EX_ECALL
//   current_state[3:0]- registered state code for the control unit
//   is_halted         - sticky halt flag, cleared only by reset
//   illegal_inst      - one-cycle pulse after an undecodable opcode
//   inst_retired[31:0], cycle_count[31:0] - present only when MICROSEQ_PERF_CNT_EN is defined
module micro_sequencer #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] part_of_inst,
    input  logic       mem_ready,
    input  logic       halt_req,
    output logic [3:0] current_state,
    output logic       is_halted,
    output logic       illegal_inst
`ifdef MICROSEQ_PERF_CNT_EN
    ,
    output logic [31:0] inst_retired,
    output logic [31:0] cycle_count
`endif
);

    typedef enum logic [3:0] {
        IF_PC          = 4'd0,
        ID_REG_FETCH   = 4'd1,
        EX_R           = 4'd2,
        EX_IMM         = 4'd3,
        WB_R_I         = 4'd4,
        EX_LD_SD       = 4'd5,
        MEM_READ       = 4'd6,
        WB_LD          = 4'd7,
        MEM_WRITE      = 4'd8,
        EX_BRANCH_COND = 4'd9,
        EX_WB_JAL      = 4'd10,
        EX_WB_JALR     = 4'd11,
        EX_ECALL       = 4'd12
    } state_t;

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    state_t state_q;
    state_t state_d;
    logic   halt_d;
    logic   illegal_d;

    assign current_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= state_t'(RESET_STATE);
            is_halted    <= 1'b0;
            illegal_inst <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_halted    <= halt_d;
            illegal_inst <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        halt_d    = is_halted;
        illegal_d = 1'b0;
        // Once halted, the machine sits in EX_ECALL ignoring every input.
        if (!is_halted) begin
            case (state_q)
                IF_PC:        if (mem_ready) state_d = ID_REG_FETCH;
                ID_REG_FETCH: begin
                    case (part_of_inst)
                        OP_ARITH:            state_d = EX_R;
                        OP_ARITH_IMM:        state_d = EX_IMM;
                        OP_LOAD, OP_STORE:   state_d = EX_LD_SD;
                        OP_BRANCH:           state_d = EX_BRANCH_COND;
                        OP_JAL:              state_d = EX_WB_JAL;
                        OP_JALR:             state_d = EX_WB_JALR;
                        OP_ECALL:            state_d = EX_ECALL;
                        default: begin
                            state_d   = IF_PC;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                EX_R, EX_IMM: state_d = WB_R_I;
                WB_R_I:       state_d = IF_PC;
                EX_LD_SD: begin
                    // Opcode is stable since decode, so only LOAD/STORE reach here.
                    if (part_of_inst == OP_LOAD)       state_d = MEM_READ;
                    else if (part_of_inst == OP_STORE) state_d = MEM_WRITE;
                    else                               state_d = IF_PC;
                end
                MEM_READ:     if (mem_ready) state_d = WB_LD;
                WB_LD:        state_d = IF_PC;
                MEM_WRITE:    if (mem_ready) state_d = IF_PC;
                EX_BRANCH_COND, EX_WB_JAL, EX_WB_JALR: state_d = IF_PC;
                EX_ECALL: begin
                    if (halt_req) halt_d  = 1'b1;
                    else          state_d = IF_PC;
                end
                default:      state_d = IF_PC;
            endcase
        end
    end

`ifdef MICROSEQ_PERF_CNT_EN
    logic retire;

    // Recovery from an unused code (13-15) is not an instruction, so it does not retire.
    assign retire = (state_q != IF_PC) && (state_q <= EX_ECALL) && (state_d == IF_PC);

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_retired <= 32'd0;
            cycle_count  <= 32'd0;
        end else begin
            if (retire)     inst_retired <= inst_retired + 32'd1;
            if (!is_halted) cycle_count  <= cycle_count + 32'd1;
        end
    end
`endif

endmodule
